pe_array_ctrl: RTL and testbench

//   Sequencer for one weight-stationary systolic PE array of border and interior PEs.

---
 rtl/pe_array_ctrl_pkg.sv | 20 ++
 rtl/pe_array_ctrl_if.sv | 23 ++
 rtl/pe_array_ctrl_cnt.sv | 20 ++
 rtl/pe_array_ctrl.sv | 140 ++++++++++++++
 tb/tb_pe_array_ctrl.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/pe_array_ctrl_pkg.sv
// pe_array_ctrl_pkg: shared FSM states, registered-output bundle and counter width helper
package pe_array_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, WLOAD, CLEAR, COMPUTE, DRAIN, DONE} ctrl_state_t;
  typedef struct packed {
    logic busy;
    logic done;
    logic en_w;
    logic clr_w;
    logic en_i;
    logic clr_i;
    logic en_o;
    logic clr_o;
    logic ifm_rd;
    logic ofm_vld;
  } ctrl_out_t;
  localparam int KWIDTH_DEF = 16;
  function automatic int cnt_w(input int kwidth);
    return kwidth + 1;
  endfunction
endpackage

// File: rtl/pe_array_ctrl_if.sv
// pe_array_ctrl_if: job handshake and PE-array control bundle
//   master: start, abort, cfg_k, cfg_wreuse out; status and array controls in
//   slave : the controller side (mirror of master)
interface pe_array_ctrl_if #(parameter int KWIDTH = 16);
  logic start;
  logic abort;
  logic [KWIDTH-1:0] cfg_k;
  logic cfg_wreuse;
  logic busy;
  logic done;
  logic en_w;
  logic clr_w;
  logic en_i;
  logic clr_i;
  logic en_o;
  logic clr_o;
  logic ifm_rd;
  logic ofm_vld;
  modport master(output start, abort, cfg_k, cfg_wreuse,
                 input busy, done, en_w, clr_w, en_i, clr_i, en_o, clr_o, ifm_rd, ofm_vld);
  modport slave(input start, abort, cfg_k, cfg_wreuse,
                output busy, done, en_w, clr_w, en_i, clr_i, en_o, clr_o, ifm_rd, ofm_vld);
endinterface

// File: rtl/pe_array_ctrl_cnt.sv
// pe_array_ctrl_cnt: loadable down-counter with zero flag (saturates at 0)
//   clk, rst_n : clock, async active-low reset
//   load, val  : load val this cycle (wins over dec)
//   dec        : decrement
//   cnt, zero  : current count, count == 0
module pe_array_ctrl_cnt #(parameter int W = 17) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] val,
  output logic [W-1:0] cnt,
  output logic         zero
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= val;
    else if (dec && !zero) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/pe_array_ctrl.sv
// pe_array_ctrl: job sequencer for a weight-stationary systolic PE array
//   clk, rst_n : clock, async active-low reset
//   bus        : pe_array_ctrl_if.slave (start/abort/cfg in; busy/done/enables/ifm_rd/ofm_vld out)
//   perf_cyc, perf_jobs : only with PE_ARRAY_CTRL_PERF_EN defined
module pe_array_ctrl
  import pe_array_ctrl_pkg::*;
#(
  parameter int ROWS   = 16,
  parameter int COLS   = 16,
  parameter int KWIDTH = KWIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  pe_array_ctrl_if.slave     bus
`ifdef PE_ARRAY_CTRL_PERF_EN
  ,
  output logic [31:0]        perf_cyc,
  output logic [15:0]        perf_jobs
`endif
);
  localparam int CW = cnt_w(KWIDTH);
  if (ROWS + COLS - 1 >= (1 << KWIDTH)) begin : g_chk
    $error("ROWS+COLS-1 must be below 2**KWIDTH");
  end
  ctrl_state_t state, state_nx;
  ctrl_out_t o_q, o_d;
  logic wvalid, set_wv, ld, dec, zero, accept;
  logic [KWIDTH-1:0] k_q;
  logic [CW-1:0] ld_val, cnt, c;
  pe_array_ctrl_cnt #(.W(CW)) u_cnt (
    .clk(clk), .rst_n(rst_n), .load(ld), .dec(dec), .val(ld_val), .cnt(cnt), .zero(zero)
  );
  // outputs are registered, so o_q.busy still covers the done cycle; gating on it
  // drops a start that coincides with done
  assign accept = state == IDLE && !o_q.busy && bus.start;
  always_comb begin
    state_nx = state;
    o_d = '0;
    ld = 1'b0;
    ld_val = '0;
    dec = 1'b0;
    set_wv = 1'b0;
    unique case (state)
      IDLE: if (accept) begin
        o_d.busy = 1'b1;
        state_nx = (bus.cfg_k == '0) ? DONE : (bus.cfg_wreuse && wvalid) ? CLEAR : WLOAD;
        o_d.clr_w = state_nx == WLOAD;
        ld = 1'b1;
        ld_val = CW'(ROWS - 1);
      end
      WLOAD: begin
        o_d.busy = 1'b1;
        o_d.en_w = 1'b1;
        dec = 1'b1;
        set_wv = zero;
        state_nx = zero ? CLEAR : WLOAD;
      end
      CLEAR: begin
        o_d.busy = 1'b1;
        o_d.clr_i = 1'b1;
        o_d.clr_o = 1'b1;
        ld = 1'b1;
        ld_val = CW'(k_q) - CW'(1);
        state_nx = COMPUTE;
      end
      COMPUTE: begin
        o_d.busy = 1'b1;
        o_d.ifm_rd = 1'b1;
        o_d.en_i = 1'b1;
        o_d.en_o = 1'b1;
        o_d.ofm_vld = c >= CW'(ROWS);
        ld = zero;
        ld_val = CW'(ROWS + COLS - 2);
        dec = 1'b1;
        state_nx = zero ? DRAIN : COMPUTE;
      end
      DRAIN: begin
        o_d.busy = 1'b1;
        o_d.en_i = 1'b1;
        o_d.en_o = 1'b1;
        o_d.ofm_vld = c >= CW'(ROWS);
        dec = 1'b1;
        state_nx = zero ? DONE : DRAIN;
      end
      DONE: begin
        o_d.busy = 1'b1;
        o_d.done = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (bus.abort) begin
      state_nx = IDLE;
      o_d = '0;
      ld = 1'b0;
      set_wv = 1'b0;
    end
  end
  // c is the compute+drain phase index; drain ends at c = T-1, which closes the ofm_vld window
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      o_q <= '0;
      wvalid <= 1'b0;
      k_q <= '0;
      c <= '0;
    end else begin
      state <= state_nx;
      o_q <= o_d;
      wvalid <= !bus.abort && (wvalid || set_wv);
      if (accept) k_q <= bus.cfg_k;
      c <= (!bus.abort && (state == COMPUTE || state == DRAIN)) ? c + 1'b1 : '0;
    end
  assign bus.busy = o_q.busy;
  assign bus.done = o_q.done;
  assign bus.en_w = o_q.en_w;
  assign bus.clr_w = o_q.clr_w;
  assign bus.en_i = o_q.en_i;
  assign bus.clr_i = o_q.clr_i;
  assign bus.en_o = o_q.en_o;
  assign bus.clr_o = o_q.clr_o;
  assign bus.ifm_rd = o_q.ifm_rd;
  assign bus.ofm_vld = o_q.ofm_vld;
`ifdef PE_ARRAY_CTRL_PERF_EN
  logic [31:0] run;
  // run counts busy cycles so far; the done cycle itself adds one more
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      run <= '0;
      perf_cyc <= '0;
      perf_jobs <= '0;
    end else begin
      run <= o_d.busy ? (state == IDLE ? 32'd1 : run + 32'd1) : '0;
      if (o_d.done) begin
        perf_cyc <= run + 32'd1;
        perf_jobs <= perf_jobs + 16'd1;
      end
    end
`endif
endmodule

// File: tb/tb_pe_array_ctrl.sv
// tb_pe_array_ctrl: directed and randomized job checks against a cycle-indexed job model
module tb_pe_array_ctrl;
  localparam int R = 4;
  localparam int C = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  bit wv_m = 1'b0;
  int jobs_m = 0;
  int cyc_m = 0;
  logic [9:0] vec;
  pe_array_ctrl_if #(.KWIDTH(16)) bus ();
`ifdef PE_ARRAY_CTRL_PERF_EN
  logic [31:0] perf_cyc;
  logic [15:0] perf_jobs;
  pe_array_ctrl #(.ROWS(R), .COLS(C), .KWIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .perf_cyc(perf_cyc), .perf_jobs(perf_jobs)
  );
`else
  pe_array_ctrl #(.ROWS(R), .COLS(C), .KWIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif
  always #5 clk = ~clk;
  assign vec = {bus.busy, bus.done, bus.en_w, bus.clr_w, bus.en_i, bus.clr_i,
                bus.en_o, bus.clr_o, bus.ifm_rd, bus.ofm_vld};
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask
  // expected {busy,done,en_w,clr_w,en_i,clr_i,en_o,clr_o,ifm_rd,ofm_vld} in job cycle n
  function automatic logic [9:0] exp_vec(input int n, input int k, input bit ld);
    int w, cs, t;
    bit run, clr;
    if (k == 0) return {1'b1, n == 1, 8'b0};
    w = ld ? R : 0;
    cs = 2 + w;
    t = k + R + C - 1;
    run = n >= cs && n < cs + t;
    clr = n == 1 + w;
    return {n <= cs + t, n == cs + t, ld && n >= 1 && n <= R, ld && n == 0,
            run, clr, run, clr, n >= cs && n < cs + k, run && (n - cs) >= R};
  endfunction
  function automatic int job_len(input int k, input bit ld);
    return (k == 0) ? 2 : 3 + (ld ? R : 0) + k + R + C - 1;
  endfunction
  task automatic perf_check();
`ifdef PE_ARRAY_CTRL_PERF_EN
    check("perf_jobs", 32'(perf_jobs), 32'(jobs_m & 16'hffff));
    check("perf_cyc", perf_cyc, 32'(cyc_m));
`endif
  endtask
  task automatic do_job(input int k, input bit reuse, input bit hold, input int abort_at);
    bit ld;
    int len;
    ld = !(reuse && wv_m);
    len = job_len(k, ld);
    bus.start = 1'b1;
    bus.cfg_k = 16'(k);
    bus.cfg_wreuse = reuse;
    @(posedge clk); #1;
    if (!hold) bus.start = 1'b0;
    bus.cfg_k = 16'($urandom);
    bus.cfg_wreuse = 1'($urandom);
    for (int n = 0; n < len; n++) begin
      check($sformatf("job k%0d ld%0d cyc%0d", k, ld, n), 32'(vec), 32'(exp_vec(n, k, ld)));
      if (n == abort_at) begin
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        wv_m = 1'b0;
        if (n == len - 1) begin
          jobs_m++;
          cyc_m = len;
        end
        for (int i = 0; i < 2; i++) begin
          check($sformatf("abort idle %0d", i), 32'(vec), 32'd0);
          @(posedge clk); #1;
        end
        perf_check();
        return;
      end
      @(posedge clk); #1;
    end
    if (k != 0 && ld) wv_m = 1'b1;
    jobs_m++;
    cyc_m = len;
    check($sformatf("post-job idle k%0d", k), 32'(vec), 32'd0);
    perf_check();
  endtask
  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.cfg_k = '0;
    bus.cfg_wreuse = 1'b0;
    #2;
    check("reset outputs", 32'(vec), 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle after reset", 32'(vec), 32'd0);
    perf_check();
    do_job(8, 1'b1, 1'b0, -1);
    do_job(8, 1'b1, 1'b0, -1);
    do_job(0, 1'b0, 1'b0, -1);
    do_job(1, 1'b1, 1'b0, -1);
    do_job(8, 1'b0, 1'b0, 3);
    do_job(5, 1'b1, 1'b0, -1);
    do_job(6, 1'b0, 1'b1, -1);
    do_job(6, 1'b1, 1'b0, -1);
    bus.start = 1'b1;
    bus.cfg_k = 16'd8;
    bus.cfg_wreuse = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #3;
    check("mid-compute before reset", 32'(bus.en_i), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async reset outputs", 32'(vec), 32'd0);
    check("async reset busy", 32'(bus.busy), 32'd0);
    wv_m = 1'b0;
    jobs_m = 0;
    cyc_m = 0;
    @(posedge clk); #1;
    check("held in reset", 32'(vec), 32'd0);
    perf_check();
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_job(3, 1'b1, 1'b0, -1);
    for (int j = 0; j < 20; j++) begin
      int k, ab;
      bit reuse;
      k = $urandom_range(0, 24);
      reuse = 1'($urandom_range(0, 1));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : -1;
      do_job(k, reuse, 1'b0, ab);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
